mem_port_arbiter: RTL and testbench

Two-master arbiter sharing the single 256-bit data-memory port between the instruction cache (master 0) and the data cache (master 1). Each master drives the same enable/write/address/data bundle it would drive to memory directly; the arbiter grants one master at a time, forwards its bundle to memory, and routes the acknowledge back. A grant is held across back-to-back transactions, such as write-back followed by refill. A forced one-cycle gap after every ack separates memory transactions cleanly.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Used by mem_arb_pick (winner selection) and mem_port_arbiter (top).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam logic M_ICACHE = 1'b0;
    localparam logic M_DCACHE = 1'b1;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    // Master that wins when exactly one request line is high.
    function automatic logic sole_requester(input logic [1:0] req);
        return req[1] ? M_DCACHE : M_ICACHE;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the dcache wins every tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        winner_o = sole_requester(req_i);
        if (req_i == 2'b11) begin
            winner_o = ~last_i;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        winner_o = sole_requester(req_i);
        if (req_i == 2'b11) begin
            winner_o = M_DCACHE;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache (master 0) and dcache (master 1).
// Tie policy set by MEM_ARB_RR_EN (see mem_arb_pick).
//   state | meaning
//   IDLE  | no grant, arbitration happens here only
//   BUSY  | granted master forwarded to memory
//   GAP   | one dead cycle after an ack; granted master may re-lock
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m0_ack_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q,  last_d;

    logic [1:0]        req;
    logic              pick;
    logic              gnt_enable;
    logic              gnt_write;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              busy;

    assign req = {m1_enable_i, m0_enable_i};

    mem_arb_pick u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick)
    );

    // Bundle of the granted master; also drives addr/data outside BUSY.
    assign gnt_enable = (grant_q == M_DCACHE) ? m1_enable_i : m0_enable_i;
    assign gnt_write  = (grant_q == M_DCACHE) ? m1_write_i  : m0_write_i;
    assign gnt_addr   = (grant_q == M_DCACHE) ? m1_addr_i   : m0_addr_i;
    assign gnt_data   = (grant_q == M_DCACHE) ? m1_data_i   : m0_data_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The ack wins over a same-cycle enable drop.
                if (mem_ack_i) begin
                    last_d  = grant_q;
                    state_d = GAP;
                end else if (!gnt_enable) begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                state_d = gnt_enable ? BUSY : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= M_ICACHE;
            last_q  <= M_ICACHE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode the state register, so the async reset clears them at once.
    assign busy         = (state_q == BUSY);
    assign mem_enable_o = busy & gnt_enable;
    assign mem_write_o  = busy & gnt_write;
    assign mem_addr_o   = gnt_addr;
    assign mem_data_o   = gnt_data;

    assign m0_ack_o = busy & (grant_q == M_ICACHE) & mem_ack_i;
    assign m1_ack_o = busy & (grant_q == M_DCACHE) & mem_ack_i;
    assign m_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i, mem_addr_o;
    logic [DW-1:0] m0_data_i, m1_data_i, m_data_o, mem_data_o, mem_data_i;
    logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, mem_ack_i;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m0_enable_i  (m0_enable_i),
        .m0_write_i   (m0_write_i),
        .m0_addr_i    (m0_addr_i),
        .m0_data_i    (m0_data_i),
        .m1_enable_i  (m1_enable_i),
        .m1_write_i   (m1_write_i),
        .m1_addr_i    (m1_addr_i),
        .m1_data_i    (m1_data_i),
        .m0_ack_o     (m0_ack_o),
        .m1_ack_o     (m1_ack_o),
        .m_data_o     (m_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic do_reset();
        rst_i       = 1'b0;
        m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = 32'h100;
        m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = 32'h200;
        m0_data_i   = {32{8'h0F}};
        m1_data_i   = {32{8'hF0}};
        mem_ack_i   = 1'b0;
        mem_data_i  = {32{8'h5A}};
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    typedef struct packed {
        logic        m0_en;
        logic        m1_en;
        logic        m1_wr;
        logic [31:0] m1_addr;
        logic        ack;
        logic [3:0]  exp_ctrl;   // {mem_enable, mem_write, m0_ack, m1_ack}
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt[13];

    // Reference model: who holds the port, which phase the port is in, who was served last.
    int  ph;      // 0 = free, 1 = transferring, 2 = dead cycle after ack
    int  holder;
    int  lst;

    logic [DW-1:0] aa_line;
    logic          tie_exp[4];

    initial begin
        aa_line = {32{8'hAA}};

        vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 4'b0000, 32'h100};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h800, 1'b0, 4'b0000, 32'h100};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h800, 1'b0, 4'b1100, 32'h800};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h800, 1'b1, 4'b1101, 32'h800};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h400, 1'b1, 4'b0000, 32'h400};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h400, 1'b0, 4'b1000, 32'h400};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h400, 1'b1, 4'b1001, 32'h400};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 4'b0000, 32'h400};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 4'b0000, 32'h400};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 4'b1000, 32'h100};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'h420, 1'b0, 4'b0000, 32'h100};
        vt[11] = '{1'b0, 1'b1, 1'b0, 32'h420, 1'b0, 4'b0000, 32'h100};
        vt[12] = '{1'b0, 1'b1, 1'b0, 32'h420, 1'b0, 4'b1000, 32'h420};

`ifdef MEM_ARB_RR_EN
        tie_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        tie_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // Reset values
        do_reset();
        #1;
        chk("rst_ctrl", {mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o}, 4'b0000);
        chk("rst_addr", mem_addr_o, 32'h100);
        chk("rst_data", mem_data_o, {32{8'h0F}});

        // Directed table: spurious acks, write-back + refill lock, abandon, handover
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            m0_enable_i = vt[i].m0_en;
            m1_enable_i = vt[i].m1_en;
            m1_write_i  = vt[i].m1_wr;
            m1_addr_i   = vt[i].m1_addr;
            mem_ack_i   = vt[i].ack;
            #1;
            chk($sformatf("tbl%0d_ctrl", i), {mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o}, vt[i].exp_ctrl);
            chk($sformatf("tbl%0d_addr", i), mem_addr_o, vt[i].exp_addr);
        end

        // Asynchronous reset in the middle of an m1 read
        do_reset();
        @(negedge clk_i);
        m1_enable_i = 1'b1; m1_addr_i = 32'h400;
        @(negedge clk_i); #1;
        chk("arst_pre_en", mem_enable_o, 1'b1);
        mem_ack_i = 1'b1;
        #1;
        rst_i = 1'b0;
        #1;
        chk("arst_ctrl", {mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o}, 4'b0000);
        chk("arst_addr", mem_addr_o, 32'h100);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("arst_idle_en", mem_enable_o, 1'b0);
        @(negedge clk_i); #1;
        chk("arst_regrant", {mem_enable_o, mem_addr_o}, {1'b1, 32'h400});
        m1_enable_i = 1'b0;

        // m1 reads 0x420, memory acks in the fifth busy cycle
        do_reset();
        @(negedge clk_i);
        m1_enable_i = 1'b1; m1_addr_i = 32'h0000_0420; mem_data_i = aa_line;
        #1;
        chk("rd_c0_en", mem_enable_o, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            mem_ack_i = (c == 5);
            #1;
            chk($sformatf("rd_c%0d", c), {mem_enable_o, mem_addr_o, m0_ack_o, m1_ack_o},
                {1'b1, 32'h420, 1'b0, (c == 5)});
        end
        chk("rd_data", m_data_o, aa_line);
        @(negedge clk_i);
        mem_ack_i = 1'b0; m1_enable_i = 1'b0;
        #1;
        chk("rd_gap_en", mem_enable_o, 1'b0);

        // Simultaneous requests, each master re-requests after being served
        do_reset();
        @(negedge clk_i);
        m0_enable_i = 1'b1; m1_enable_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int  w;
            logic g;
            w = 0;
            do begin
                @(negedge clk_i); #1;
                w++;
            end while (!mem_enable_o && w < 10);
            chk($sformatf("tie%0d_wait", k), mem_enable_o, 1'b1);
            g = (mem_addr_o == 32'h200);
            chk($sformatf("tie%0d_grant", k), g, tie_exp[k]);
            mem_ack_i = 1'b1;
            #1;
            chk($sformatf("tie%0d_ack", k), {m0_ack_o, m1_ack_o}, {~g, g});
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (g) m1_enable_i = 1'b0; else m0_enable_i = 1'b0;
            @(negedge clk_i);
            m0_enable_i = 1'b1; m1_enable_i = 1'b1;
        end

        // Randomized traffic against the reference model
        do_reset();
        ph = 0; holder = 0; lst = 0;
        for (int n = 0; n < 3000; n++) begin
            logic          en[2], wr[2];
            logic [AW-1:0] ad[2];
            logic [DW-1:0] dt[2];
            logic          busy_m;
            @(negedge clk_i);
            if ($urandom_range(3) == 0) m0_enable_i = ~m0_enable_i;
            if ($urandom_range(3) == 0) m1_enable_i = ~m1_enable_i;
            m0_write_i = $urandom_range(1);
            m1_write_i = $urandom_range(1);
            if ($urandom_range(7) == 0) m0_addr_i = $urandom();
            if ($urandom_range(7) == 0) m1_addr_i = $urandom();
            if ($urandom_range(7) == 0) m0_data_i = rand_line();
            if ($urandom_range(7) == 0) m1_data_i = rand_line();
            mem_data_i = rand_line();
            mem_ack_i  = ($urandom_range(3) == 0);
            #1;
            en[0] = m0_enable_i; en[1] = m1_enable_i;
            wr[0] = m0_write_i;  wr[1] = m1_write_i;
            ad[0] = m0_addr_i;   ad[1] = m1_addr_i;
            dt[0] = m0_data_i;   dt[1] = m1_data_i;
            busy_m = (ph == 1);
            chk("rnd_ctrl", {mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o},
                {busy_m && en[holder], busy_m && wr[holder],
                 busy_m && holder == 0 && mem_ack_i, busy_m && holder == 1 && mem_ack_i});
            chk("rnd_addr",  mem_addr_o, ad[holder]);
            chk("rnd_wdata", mem_data_o, dt[holder]);
            chk("rnd_rdata", m_data_o,   mem_data_i);
            case (ph)
                0: if (en[0] || en[1]) begin
                    if (en[0] && en[1]) begin
`ifdef MEM_ARB_RR_EN
                        holder = 1 - lst;
`else
                        holder = 1;
`endif
                    end else begin
                        holder = en[1] ? 1 : 0;
                    end
                    ph = 1;
                end
                1: if (mem_ack_i) begin
                    ph  = 2;
                    lst = holder;
                end else if (!en[holder]) begin
                    ph = 0;
                end
                default: ph = en[holder] ? 1 : 0;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
